// File: rtl/snina_alarm_unit.sv
// Per-domain alarm FSMs behind the andSNINA gadget (d=1, k=1).
// Optional alarm clear: define SNINA_ALARM_CLEAR_EN.
module snina_alarm_unit #(
    parameter int N_SHARES   = 2,
    parameter int K          = 1,
    parameter int WARMUP_CYC = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [K:0]       in_c_0,
    input  logic [K:0]       in_c_1,
    input  logic             in_ok_0,
    input  logic             in_ok_1,
    input  logic             clr_0,
    input  logic             clr_1,
    output logic             out_valid_0,
    output logic             out_valid_1,
    output logic [K:0]       out_c_0,
    output logic [K:0]       out_c_1,
    output logic             alarm_0,
    output logic             alarm_1,
    output logic [CNT_W-1:0] fcnt_0,
    output logic [CNT_W-1:0] fcnt_1
);
    localparam int WW = $clog2(WARMUP_CYC + 1);

    typedef enum logic [1:0] {
        WARMUP,
        RUN,
        ALARM
    } state_t;

    logic [K:0] c_in   [N_SHARES];
    logic       ok_in  [N_SHARES];
    logic       clr_in [N_SHARES];

    assign c_in[0]   = in_c_0;
    assign c_in[1]   = in_c_1;
    assign ok_in[0]  = in_ok_0;
    assign ok_in[1]  = in_ok_1;
    assign clr_in[0] = clr_0;
    assign clr_in[1] = clr_1;

    // Each domain is a fully separate instance; no signal crosses domains.
    for (genvar g = 0; g < N_SHARES; g++) begin : g_dom
        state_t           st_q;
        logic [WW-1:0]    warm_q;
        logic [K:0]       c_q;
        logic             v_q;
        logic             a_q;
        logic [CNT_W-1:0] n_q;
        logic [CNT_W-1:0] n_d;
        logic             same;
        logic             fault;
        logic             clr;

        assign same  = (&c_in[g]) | ~(|c_in[g]);
        assign fault = in_valid & (~ok_in[g] | ~same);
        assign n_d   = (&n_q) ? n_q : n_q + 1'b1;
`ifdef SNINA_ALARM_CLEAR_EN
        assign clr   = clr_in[g];
`else
        assign clr   = 1'b0;
        logic unused_clr;
        assign unused_clr = clr_in[g];
`endif

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                st_q   <= WARMUP;
                warm_q <= '0;
                c_q    <= '0;
                v_q    <= 1'b0;
                a_q    <= 1'b0;
                n_q    <= '0;
            end else begin
                unique case (st_q)
                    WARMUP: begin
                        c_q <= '0;
                        v_q <= 1'b0;
                        a_q <= 1'b0;
                        if (warm_q == WW'(WARMUP_CYC - 1)) begin
                            st_q <= RUN;
                        end else begin
                            warm_q <= warm_q + 1'b1;
                        end
                    end
                    RUN: begin
                        if (fault) begin
                            st_q <= ALARM;
                            a_q  <= 1'b1;
                            c_q  <= '0;
                            v_q  <= 1'b0;
                            n_q  <= n_d;
                        end else begin
                            c_q <= in_valid ? c_in[g] : '0;
                            v_q <= in_valid;
                        end
                    end
                    default: begin
                        c_q <= '0;
                        v_q <= 1'b0;
                        if (fault) n_q <= n_d;
                        // Clear wins over a concurrent fault, which is still counted.
                        if (clr) begin
                            st_q   <= WARMUP;
                            warm_q <= '0;
                            a_q    <= 1'b0;
                        end else begin
                            a_q <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign out_valid_0 = g_dom[0].v_q;
    assign out_valid_1 = g_dom[1].v_q;
    assign out_c_0     = g_dom[0].c_q;
    assign out_c_1     = g_dom[1].c_q;
    assign alarm_0     = g_dom[0].a_q;
    assign alarm_1     = g_dom[1].a_q;
    assign fcnt_0      = g_dom[0].n_q;
    assign fcnt_1      = g_dom[1].n_q;

endmodule

// File: tb/tb_snina_alarm_unit.sv
// Self-checking bench for snina_alarm_unit: reference model plus
// directed scenarios with literal expectations.
module tb_snina_alarm_unit;
    localparam int WARM = 2;
    localparam int CMAX = 255;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [1:0] in_c_0, in_c_1;
    logic       in_ok_0, in_ok_1;
    logic       clr_0, clr_1;
    logic       out_valid_0, out_valid_1;
    logic [1:0] out_c_0, out_c_1;
    logic       alarm_0, alarm_1;
    logic [7:0] fcnt_0, fcnt_1;

    int n_pass = 0;
    int n_tot  = 0;

    snina_alarm_unit dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_c_0      (in_c_0),
        .in_c_1      (in_c_1),
        .in_ok_0     (in_ok_0),
        .in_ok_1     (in_ok_1),
        .clr_0       (clr_0),
        .clr_1       (clr_1),
        .out_valid_0 (out_valid_0),
        .out_valid_1 (out_valid_1),
        .out_c_0     (out_c_0),
        .out_c_1     (out_c_1),
        .alarm_0     (alarm_0),
        .alarm_1     (alarm_1),
        .fcnt_0      (fcnt_0),
        .fcnt_1      (fcnt_1)
    );

    always #5 clk = ~clk;

    // Reference model: per domain, edges since (re)start, alarm flag,
    // fault total and the outputs the registers must show.
    int   since [2];
    bit   alm   [2];
    int   cnt   [2];
    bit   ev    [2];
    int   ec    [2];

    function automatic bit is_fault(logic v, logic [1:0] c, logic ok);
        return v && (!ok || (c != 2'b00 && c != 2'b11));
    endfunction

    function automatic bit clear_on(logic c);
`ifdef SNINA_ALARM_CLEAR_EN
        return c;
`else
        return (c && 1'b0);
`endif
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                since[d] = 0; alm[d] = 0; cnt[d] = 0;
                ev[d] = 0; ec[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                bit f;
                f = is_fault(in_valid, d ? in_c_1 : in_c_0,
                             d ? in_ok_1 : in_ok_0);
                ev[d] = 0;
                ec[d] = 0;
                if (alm[d]) begin
                    if (f) cnt[d] = (cnt[d] < CMAX) ? cnt[d] + 1 : CMAX;
                    if (clear_on(d ? clr_1 : clr_0)) begin
                        alm[d]   = 0;
                        since[d] = 0;
                    end
                end else if (since[d] < WARM) begin
                    since[d]++;
                end else if (f) begin
                    alm[d] = 1;
                    cnt[d] = (cnt[d] < CMAX) ? cnt[d] + 1 : CMAX;
                end else begin
                    ev[d] = in_valid;
                    ec[d] = in_valid ? int'(d ? in_c_1 : in_c_0) : 0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        n_tot++;
        if (out_valid_0 === ev[0] && out_valid_1 === ev[1] &&
            int'(out_c_0) == ec[0] && int'(out_c_1) == ec[1] &&
            !$isunknown({out_c_0, out_c_1, fcnt_0, fcnt_1}) &&
            alarm_0 === alm[0] && alarm_1 === alm[1] &&
            int'(fcnt_0) == cnt[0] && int'(fcnt_1) == cnt[1]) begin
            n_pass++;
        end else begin
            $display("FAIL model t=%0t got v=%b%b c=%0d/%0d a=%b%b n=%0d/%0d want v=%b%b c=%0d/%0d a=%b%b n=%0d/%0d",
                     $time, out_valid_0, out_valid_1, out_c_0, out_c_1,
                     alarm_0, alarm_1, fcnt_0, fcnt_1, ev[0], ev[1],
                     ec[0], ec[1], alm[0], alm[1], cnt[0], cnt[1]);
        end
    end

    task automatic chk(string name, int act, int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s got %0d want %0d", name, act, exp);
    endtask

    task automatic drv(logic v, logic [1:0] c0, logic [1:0] c1,
                       logic ok0, logic ok1, logic cl0, logic cl1, int n);
        in_valid = v;  in_c_0 = c0; in_c_1 = c1;
        in_ok_0 = ok0; in_ok_1 = ok1;
        clr_0 = cl0;   clr_1 = cl1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1; in_c_0 = 2'b11; in_c_1 = 2'b00;
        in_ok_0 = 1;  in_ok_1 = 1; clr_0 = 0; clr_1 = 0;
        #1 reset = 1'b0;
        #1;
        chk("rst_valid0", int'(out_valid_0), 0);
        chk("rst_alarm1", int'(alarm_1), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Warm-up then first sampled result
        drv(1, 2'b11, 2'b00, 1, 1, 0, 0, 2);
        chk("warm_valid0", int'(out_valid_0), 0);
        drv(1, 2'b11, 2'b00, 1, 1, 0, 0, 1);
        chk("first_c0", int'(out_c_0), 3);
        chk("first_v0", int'(out_valid_0), 1);

        // Data patterns pass with one cycle latency
        drv(1, 2'b00, 2'b11, 1, 1, 0, 0, 1);
        drv(1, 2'b11, 2'b00, 1, 1, 0, 0, 1);
        drv(1, 2'b00, 2'b11, 1, 1, 0, 0, 1);
        chk("pat_c0", int'(out_c_0), 0);
        chk("pat_c1", int'(out_c_1), 3);
        drv(0, 2'b11, 2'b11, 1, 1, 0, 0, 1);
        chk("idle_c0", int'(out_c_0), 0);

        // Domain 1 flag fault
        drv(1, 2'b11, 2'b11, 1, 0, 0, 0, 1);
        chk("f1_alarm", int'(alarm_1), 1);
        chk("f1_cnt", int'(fcnt_1), 1);
        chk("f1_c0", int'(out_c_0), 3);
        drv(1, 2'b11, 2'b11, 1, 1, 0, 0, 2);
        chk("f1_c1", int'(out_c_1), 0);
        chk("f1_alarm0", int'(alarm_0), 0);

        // Copy mismatch on domain 0; invalid cycles ignored
        drv(0, 2'b01, 2'b00, 0, 1, 0, 0, 2);
        chk("inv_cnt0", int'(fcnt_0), 0);
        chk("inv_alarm0", int'(alarm_0), 0);
        drv(1, 2'b01, 2'b00, 1, 1, 0, 0, 1);
        chk("cp_alarm0", int'(alarm_0), 1);
        chk("cp_v0", int'(out_valid_0), 0);
        chk("cp_cnt0", int'(fcnt_0), 1);

        // Clear request on domain 0
        drv(1, 2'b11, 2'b00, 1, 1, 1, 0, 1);
`ifdef SNINA_ALARM_CLEAR_EN
        chk("clr_alarm0", int'(alarm_0), 0);
`else
        chk("clr_alarm0", int'(alarm_0), 1);
`endif
        drv(1, 2'b11, 2'b00, 1, 1, 0, 0, 2);
        chk("clr_warm_v0", int'(out_valid_0), 0);
        drv(1, 2'b11, 2'b00, 1, 1, 0, 0, 1);
`ifdef SNINA_ALARM_CLEAR_EN
        chk("clr_pass_v0", int'(out_valid_0), 1);
`else
        chk("clr_pass_v0", int'(out_valid_0), 0);
`endif
        chk("clr_cnt0", int'(fcnt_0), 1);

        // Counter saturation, simultaneous faults
        drv(1, 2'b11, 2'b00, 0, 0, 0, 0, 300);
        chk("sat_cnt0", int'(fcnt_0), 255);
        chk("sat_cnt1", int'(fcnt_1), 255);
        chk("sat_alarm0", int'(alarm_0), 1);

        // Asynchronous reset mid-cycle
        #2 reset = 1'b0;
        #1;
        chk("arst_alarm0", int'(alarm_0), 0);
        chk("arst_cnt1", int'(fcnt_1), 0);
        chk("arst_v0", int'(out_valid_0), 0);
        @(negedge clk);
        drv(1, 2'b11, 2'b00, 1, 1, 0, 0, 1);
        reset = 1'b1;
        drv(1, 2'b00, 2'b11, 1, 1, 0, 0, 3);
        chk("rerun_c1", int'(out_c_1), 3);
        chk("rerun_v1", int'(out_valid_1), 1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
